// File: rtl/ternary_perceptron_seq.sv
// Sequential ternary-weight perceptron: one multiply-accumulate step per clock over N_IN signed inputs.
// Vectors enter and results leave on valid/ready handshakes; weights are writable at run time.
module ternary_perceptron_seq #(
  parameter int N_IN  = 8,
  parameter int IN_W  = 4,
  parameter int OUT_W = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wt_we,
  input  logic [$clog2(N_IN)-1:0]   wt_addr,
  input  logic [1:0]                wt_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN*IN_W-1:0]      in_data,
  input  logic signed [OUT_W-1:0]   threshold,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_sum,
  output logic                      out_fire,
  output logic                      busy
);

  localparam int AW      = $clog2(N_IN);
  localparam int ACC_W   = IN_W + $clog2(N_IN) + 1;
  localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (OUT_W - 1));

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state;
  logic [1:0]              weights [N_IN];
  logic signed [IN_W-1:0]  x_reg [N_IN];
  logic signed [OUT_W-1:0] thr_reg;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] term;
  logic [AW-1:0]           idx;
  int                      acc_int;
  int                      sat_int;
  logic                    last_step;

  // Next accumulator value for the current element, plus its clamped form for the final step.
  always_comb begin
    term    = ACC_W'(x_reg[idx]);
    acc_nxt = acc;
    case (weights[idx])
      2'b01:   acc_nxt = acc + term;
      2'b11:   acc_nxt = acc - term;
      default: acc_nxt = acc;
    endcase
    acc_int = int'(acc_nxt);
    sat_int = acc_int;
    if (acc_int > SAT_MAX) sat_int = SAT_MAX;
    if (acc_int < SAT_MIN) sat_int = SAT_MIN;
    last_step = (idx == AW'(N_IN - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_fire  <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      for (int i = 0; i < N_IN; i++) weights[i] <= 2'b00;
    end else begin
      // A write in an ACCUM cycle lands after that cycle's term has already used the old code.
      if (wt_we && (int'(wt_addr) < N_IN)) weights[wt_addr] <= wt_data;

      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int i = 0; i < N_IN; i++) x_reg[i] <= in_data[i*IN_W +: IN_W];
            thr_reg  <= threshold;
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_nxt;
          idx <= idx + AW'(1);
          if (last_step) begin
            idx       <= '0;
            out_sum   <= OUT_W'(sat_int);
            out_fire  <= (acc_int >= int'(thr_reg));
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_perceptron_seq.sv
// Directed self-checking bench for ternary_perceptron_seq with hand-computed expected sums and fire bits.
module tb_ternary_perceptron_seq;

  logic              clk = 1'b0;
  logic              reset;
  logic              wt_we;
  logic [2:0]        wt_addr;
  logic [1:0]        wt_data;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic signed [5:0] threshold;
  logic              out_valid;
  logic              out_ready;
  logic signed [5:0] out_sum;
  logic              out_fire;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic signed [3:0] xv [8];

  ternary_perceptron_seq #(.N_IN(8), .IN_W(4), .OUT_W(6)) dut (
    .clk(clk), .reset(reset), .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .threshold(threshold),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_fire(out_fire),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic packVector();
    for (int i = 0; i < 8; i++) in_data[i*4 +: 4] = xv[i];
  endtask

  task automatic writeWeight(input int addr, input logic [1:0] code);
    wt_we   = 1'b1;
    wt_addr = 3'(addr);
    wt_data = code;
    tick();
    wt_we   = 1'b0;
  endtask

  task automatic setAllWeights(input logic [1:0] even_code, input logic [1:0] odd_code);
    for (int i = 0; i < 8; i++) writeWeight(i, (i % 2 == 0) ? even_code : odd_code);
  endtask

  task automatic acceptVector(input logic signed [5:0] thr);
    packVector();
    threshold = thr;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic waitResult(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_timeout observed=%0d expected=valid", tag, n);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Full transaction: accept, check latency, result and fire bit, then hand the result off.
  task automatic applyStimulus(input string tag, input logic signed [5:0] thr,
                               input int exp_sum, input logic exp_fire);
    int n;
    acceptVector(thr);
    checkOutput({tag, "_busy"}, busy, 1);
    waitResult(tag, n);
    checkOutput({tag, "_latency"}, n, 8);
    checkOutput({tag, "_sum"}, out_sum, exp_sum);
    checkOutput({tag, "_fire"}, out_fire, exp_fire);
    consume();
    checkOutput({tag, "_idle"}, out_valid, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; wt_we = 1'b0; wt_addr = '0; wt_data = '0;
    in_valid = 1'b0; in_data = '0; threshold = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_sum", out_sum, 0);
    checkOutput("rst_out_fire", out_fire, 0);
    checkOutput("rst_busy", busy, 0);

    // Weights all zero after reset: sum 0, 0 >= 0 fires.
    xv = '{4'sd5, 4'sd5, 4'sd5, 4'sd5, 4'sd5, 4'sd5, 4'sd5, 4'sd5};
    applyStimulus("zero_wt", 6'sd0, 0, 1'b1);

    $display("[TB] all +1 weights");
    setAllWeights(2'b01, 2'b01);
    xv = '{4'sd3, 4'sd3, 4'sd3, 4'sd3, 4'sd3, 4'sd3, 4'sd3, 4'sd3};
    applyStimulus("pos_24", 6'sd20, 24, 1'b1);
    xv = '{4'sd7, 4'sd7, 4'sd7, 4'sd7, 4'sd7, 4'sd7, 4'sd7, 4'sd7};
    applyStimulus("pos_sat", 6'sd31, 31, 1'b1);

    $display("[TB] alternating weights");
    setAllWeights(2'b01, 2'b11);
    xv = '{4'sd7, 4'sd7, -4'sd8, -4'sd8, 4'sd1, 4'sd2, 4'sd3, 4'sd4};
    applyStimulus("alt_thr_m2", -6'sd2, -2, 1'b1);
    applyStimulus("alt_thr_m1", -6'sd1, -2, 1'b0);

    $display("[TB] all -1 weights and zero codes");
    setAllWeights(2'b11, 2'b11);
    xv = '{-4'sd8, -4'sd8, -4'sd8, -4'sd8, -4'sd8, -4'sd8, -4'sd8, -4'sd8};
    applyStimulus("neg_64", 6'sd31, 31, 1'b1);
    xv = '{4'sd7, 4'sd7, 4'sd7, 4'sd7, 4'sd7, 4'sd7, 4'sd7, 4'sd7};
    applyStimulus("neg_sat", -6'sd32, -32, 1'b0);
    setAllWeights(2'b10, 2'b00);
    applyStimulus("code_zero", 6'sd1, 0, 1'b0);

    $display("[TB] backpressure");
    setAllWeights(2'b01, 2'b01);
    xv = '{4'sd1, 4'sd2, 4'sd3, 4'sd4, 4'sd5, 4'sd6, 4'sd7, -4'sd8};
    acceptVector(6'sd0);
    waitResult("bp", n);
    xv = '{4'sd7, 4'sd7, 4'sd7, 4'sd7, 4'sd7, 4'sd7, 4'sd7, 4'sd7};
    packVector();
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_hold_sum", out_sum, 20);
      checkOutput("bp_hold_in_ready", in_ready, 0);
      checkOutput("bp_hold_valid", out_valid, 1);
      tick();
    end
    checkOutput("bp_fire", out_fire, 1);
    consume();
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_no_accept_on_consume", in_ready, 1);
    in_valid = 1'b0;
    xv = '{4'sd2, 4'sd2, 4'sd2, 4'sd2, 4'sd2, 4'sd2, 4'sd2, 4'sd2};
    applyStimulus("bp_next", 6'sd0, 16, 1'b1);

    $display("[TB] reset mid-accumulate");
    acceptVector(6'sd0);
    tick(); tick(); tick();
    reset = 1'b1;
    wt_we = 1'b1; wt_addr = 3'd0; wt_data = 2'b01;
    tick();
    reset = 1'b0;
    wt_we = 1'b0;
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_sum", out_sum, 0);
    xv = '{4'sd5, 4'sd5, 4'sd5, 4'sd5, 4'sd5, 4'sd5, 4'sd5, 4'sd5};
    applyStimulus("midrst_wt_cleared", 6'sd0, 0, 1'b1);

    $display("[TB] weight write during accumulate");
    setAllWeights(2'b01, 2'b01);
    xv = '{4'sd1, 4'sd1, 4'sd1, 4'sd1, 4'sd1, 4'sd1, 4'sd1, 4'sd1};
    acceptVector(6'sd0);
    tick(); tick();
    writeWeight(2, 2'b11);
    waitResult("wt_old", n);
    checkOutput("wt_old_sum", out_sum, 8);
    consume();
    applyStimulus("wt_new", 6'sd0, 6, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
